// File: rtl/store_output_buffer.sv
// First-word-fall-through output FIFO between the row intermediator and the result writer,
// with overflow detection and end-of-matrix flush tracking. STORE_OUTPUT_BUFFER_STATS_EN adds push/drop counters.
module store_output_buffer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 4,
  parameter int DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  store,
  input  logic [DATA_W-1:0]     store_value,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  flush_done,
  output logic [ADDR_WIDTH:0]   count
`ifdef STORE_OUTPUT_BUFFER_STATS_EN
  ,
  output logic [31:0]           stored_total,
  output logic [15:0]           dropped_total
`endif
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH+1)'(AF_MARGIN);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  almost_full_q, almost_full_d;
  logic                  overflow_q, overflow_d;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Pointer, occupancy and status next-state
  always_comb begin
    pop        = (count_q != '0) && out_ready;
    push       = store && ((count_q != FULL_CNT) || pop);
    drop       = store && !push;
    rd_ptr_nxt = rd_ptr_q + PTR_ONE;
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_nxt : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end

    almost_full_d = (FULL_CNT - count_d) <= AF_CNT;
    overflow_d    = overflow_q | drop;
  end

  // Head register: the word after the popped one if one is already stored,
  // otherwise the incoming word when it becomes the only entry.
  always_comb begin
    out_data_d = out_data_q;
    if (pop && (count_q > CNT_ONE)) begin
      out_data_d = mem_q[rd_ptr_nxt];
    end else if (push && ((count_q == '0) || pop)) begin
      out_data_d = store_value;
    end
  end

  // Flush tracking: trailing stores after the flush extend the drain
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((count_d == '0) && !store) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_data_q    <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage array carries no reset; occupancy alone defines which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= store_value;
    end
  end

  assign out_valid   = (count_q != '0);
  assign out_data    = out_data_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;
  assign flush_done  = (state_q == DONE);
  assign count       = count_q;

`ifdef STORE_OUTPUT_BUFFER_STATS_EN
  logic [31:0] stored_total_q, stored_total_d;
  logic [15:0] dropped_total_q, dropped_total_d;

  // Saturating lifetime counters, untouched by flush
  always_comb begin
    stored_total_d  = stored_total_q;
    dropped_total_d = dropped_total_q;
    if (push && (stored_total_q != '1)) begin
      stored_total_d = stored_total_q + 32'd1;
    end
    if (drop && (dropped_total_q != '1)) begin
      dropped_total_d = dropped_total_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stored_total_q  <= '0;
      dropped_total_q <= '0;
    end else begin
      stored_total_q  <= stored_total_d;
      dropped_total_q <= dropped_total_d;
    end
  end

  assign stored_total  = stored_total_q;
  assign dropped_total = dropped_total_q;
`endif

endmodule

// File: tb/tb_store_output_buffer.sv
// Bench for store_output_buffer: directed scenarios plus randomized traffic compared
// against a queue-based reference model of the FIFO, overflow and flush behaviour.
module tb_store_output_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          store = 1'b0;
  logic [63:0]   store_value = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [63:0]   out_data;
  logic          almost_full;
  logic          overflow;
  logic          flush_done;
  logic [AW:0]   count;
`ifdef STORE_OUTPUT_BUFFER_STATS_EN
  logic [31:0]   stored_total;
  logic [15:0]   dropped_total;
`endif

  always #5 clk = ~clk;

  store_output_buffer #(
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .AF_MARGIN(AF),
    .DATA_W(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .store(store),
    .store_value(store_value),
    .flush(flush),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .almost_full(almost_full),
    .overflow(overflow),
    .flush_done(flush_done),
    .count(count)
`ifdef STORE_OUTPUT_BUFFER_STATS_EN
    ,
    .stored_total(stored_total),
    .dropped_total(dropped_total)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [63:0] mq[$];
  bit          m_ovf;
  bit          m_pending;
  bit          m_done;
  longint      m_stored;
  longint      m_dropped;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf     = 1'b0;
    m_pending = 1'b0;
    m_done    = 1'b0;
    m_stored  = 0;
    m_dropped = 0;
  endtask

  task automatic model_clock(input bit st, input logic [63:0] v, input bit fl, input bit rdy);
    bit pop;
    bit full;
    bit prev_done;
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    if (pop) mq.delete(0);
    if (st) begin
      if (!full || pop) begin
        mq.push_back(v);
        if (m_stored < 64'hFFFF_FFFF) m_stored++;
      end else begin
        m_ovf = 1'b1;
        if (m_dropped < 64'hFFFF) m_dropped++;
      end
    end
    prev_done = m_done;
    m_done    = 1'b0;
    if (m_pending) begin
      if ((mq.size() == 0) && !st) begin
        m_pending = 1'b0;
        m_done    = 1'b1;
      end
    end else if (!prev_done && fl) begin
      m_pending = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("valid", out_valid, (mq.size() != 0));
    if (mq.size() != 0) chk("data", out_data, mq[0]);
    chk("count", count, mq.size());
    chk("almost_full", almost_full, ((DEPTH - mq.size()) <= AF));
    chk("overflow", overflow, m_ovf);
    chk("flush_done", flush_done, m_done);
`ifdef STORE_OUTPUT_BUFFER_STATS_EN
    chk("stored_total", stored_total, m_stored);
    chk("dropped_total", dropped_total, m_dropped);
`endif
  endtask

  task automatic step(input bit st, input logic [63:0] v, input bit fl, input bit rdy);
    store       = st;
    store_value = v;
    flush       = fl;
    out_ready   = rdy;
    @(posedge clk);
    model_clock(st, v, fl, rdy);
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    store       = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    store_value = '0;
    reset       = 1'b1;
    #2;
    model_reset();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_count", count, 0);
    chk("rst_almost_full", almost_full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_flush_done", flush_done, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int  n_done;
    bit  st;
    bit  fl;
    bit  rdy;
    int  rdy_pct;

    #1;
    apply_reset();

    // Single word with hold
    step(1'b1, 64'h3FF0_0000_0000_0000, 1'b0, 1'b0);
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 64'h3FF0_0000_0000_0000);
    chk("single_count", count, 1);
    step(1'b0, 64'h0, 1'b0, 1'b0);
    chk("single_hold", out_data, 64'h3FF0_0000_0000_0000);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    chk("single_popped", count, 0);

    // Fill, overflow, ordered drain
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 64'(i), 1'b0, 1'b0);
      if (i == 11) chk("af_after_11", almost_full, 1'b0);
      if (i == 12) chk("af_after_12", almost_full, 1'b1);
    end
    chk("fill_count", count, 16);
    step(1'b1, 64'd17, 1'b0, 1'b0);
    chk("fill_overflow", overflow, 1'b1);
    chk("fill_count_kept", count, 16);
`ifdef STORE_OUTPUT_BUFFER_STATS_EN
    chk("stats_stored", stored_total, 32'd16);
    chk("stats_dropped", dropped_total, 16'd1);
`endif
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", out_data, 64'(i));
      step(1'b0, 64'h0, 1'b0, 1'b1);
    end
    chk("drain_empty", out_valid, 1'b0);
    chk("overflow_sticky", overflow, 1'b1);

    // Full with concurrent push and pop
    apply_reset();
    for (int i = 1; i <= 16; i++) step(1'b1, 64'(100 + i), 1'b0, 1'b0);
    step(1'b1, 64'd99, 1'b0, 1'b1);
    chk("full_pp_count", count, 16);
    chk("full_pp_overflow", overflow, 1'b0);
    for (int i = 2; i <= 16; i++) begin
      chk("full_pp_order", out_data, 64'(100 + i));
      step(1'b0, 64'h0, 1'b0, 1'b1);
    end
    chk("full_pp_last", out_data, 64'd99);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    chk("full_pp_empty", out_valid, 1'b0);

    // Flush with trailing stores
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 64'(11 + i), 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b1, 64'd14, 1'b0, 1'b1);
    step(1'b1, 64'd15, 1'b0, 1'b1);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 64'h0, 1'b0, 1'b1);
      if (flush_done) begin
        n_done++;
        chk("done_when_empty", count, 0);
      end
    end
    chk("flush_done_pulses", n_done, 1);

    // Empty flush latency
    apply_reset();
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("eflush_cycle1", flush_done, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0);
    chk("eflush_cycle2", flush_done, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0);
    chk("eflush_cycle3", flush_done, 1'b0);

    // Reset in the middle of a drain
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 64'(200 + i), 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0);
    chk("middrain_count", count, 5);
    apply_reset();
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 64'h0, 1'b0, 1'b1);
      if (flush_done) n_done++;
    end
    chk("middrain_no_done", n_done, 0);

    // Randomized traffic at three consumer rates
    for (int b = 0; b < 3; b++) begin
      apply_reset();
      rdy_pct = (b == 0) ? 30 : ((b == 1) ? 60 : 90);
      for (int i = 0; i < 300; i++) begin
        st  = ($urandom_range(99) < 55);
        rdy = ($urandom_range(99) < rdy_pct);
        fl  = ($urandom_range(19) == 0);
        step(st, {$urandom, $urandom}, fl, rdy);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
